// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle sequencing controller for a shared-datapath
// RISC-V core. Steps each instruction through fetch/decode/execute/memory/
// writeback, drives the datapath selects and enables, waits on a
// variable-latency memory and traps on memory timeout or illegal opcode.
// Optional feature: define MC_PERF_CNT_EN to add cycle_cnt/instret_cnt.
module mc_control_fsm #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             trap,
    output logic             illegal_instr,
    output logic [3:0]       state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Wait counter never exceeds WAIT_LIMIT-1, so this width always fits it.
    localparam int WW = $clog2(WAIT_LIMIT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_LIMIT - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          trap_q, trap_d;
    logic          illegal_q, illegal_d;
    logic          in_wait;
    logic          timeout;

    // Only funct3[0] matters (beq/bne); the other bits are deliberately ignored.
    logic unused_funct3;
    assign unused_funct3 = ^funct3[2:1];

    assign state_o       = state_q;
    assign trap          = trap_q;
    assign illegal_instr = illegal_q;

    // Immediate type follows the opcode in every state.
    always_comb begin
        unique case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // Next-state, datapath controls, timeout detection and flag updates.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;

        in_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
        timeout = in_wait && !mem_ready && (wait_q == WAIT_LAST);

        unique case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures OldPC + imm: the branch/jal target.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC loads the target from ALUOut while ALUResult forms PC+4 for rd.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = Zero ^ funct3[0];
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // A memory handshake that never completes traps; mem_ready on the last cycle still wins.
        if (timeout) state_d = S_TRAP;

        // Enables must be quiet while the controller is being reset.
        if (reset) begin
            mem_req  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end

        if ((state_d != state_q) || mem_ready || !in_wait) wait_d = '0;
        else                                               wait_d = wait_q + 1'b1;

        trap_d    = trap_q | (state_d == S_TRAP);
        illegal_d = illegal_q | ((state_q == S_DECODE) && (state_d == S_TRAP));
    end

    // State, wait counter and sticky flags; reset wins in every state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            trap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            trap_q    <= trap_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instret_q;

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

    // Performance counters: live cycles and completed instructions, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_q <= cycle_q + 1'b1;
            if ((state_q != S_FETCH) && (state_d == S_FETCH)) instret_q <= instret_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Testbench for mc_control_fsm: builds an expected per-cycle trace from the
// instruction class and chosen memory stall counts, drives the DUT from that
// trace and compares state, enables, selects and flags on every cycle.
module tb_mc_control_fsm;

    localparam int WAIT_LIMIT = 16;
    localparam int CNT_W      = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Spec state numbers.
    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5;
    localparam int EXECR = 6, ALUWB = 7, EXECI = 8, JAL = 9, BRANCH = 10, TRAP = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic       trap, illegal_instr;
    logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
`endif

    mc_control_fsm #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .trap(trap),
        .illegal_instr(illegal_instr), .state_o(state_o)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One expected cycle: state, inputs to drive during it, and expected flags.
    typedef struct {
        int         st;
        bit         mr;
        bit         rst;
        bit         trp;
        bit         ill;
        logic [6:0] op;
        bit   [2:0] f3;
        bit         z;
    } elem_t;

    elem_t      trace[$];
    logic [6:0] cur_op;
    bit   [2:0] cur_f3;
    bit         cur_z;
    bit         cur_ill;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic push(input int st, input bit mr, input bit rst);
        elem_t e;
        e.st  = st;
        e.mr  = mr;
        e.rst = rst;
        e.trp = (st == TRAP);
        e.ill = (st == TRAP) && cur_ill;
        e.op  = cur_op;
        e.f3  = cur_f3;
        e.z   = cur_z;
        trace.push_back(e);
    endtask

    // Sit in TRAP a couple of cycles, then reset out of it.
    task automatic trap_then_reset(input bit ill);
        cur_ill = ill;
        push(TRAP, 1'($urandom), 1'b0);
        push(TRAP, 1'($urandom), 1'b0);
        push(TRAP, 1'($urandom), 1'b1);
        cur_ill = 1'b0;
    endtask

    // A memory wait of 'stall' low cycles; a stall of WAIT_LIMIT or more times out.
    task automatic wait_seg(input int st, input int stall, output bit ok);
        if (stall >= WAIT_LIMIT) begin
            repeat (WAIT_LIMIT) push(st, 1'b0, 1'b0);
            trap_then_reset(1'b0);
            ok = 1'b0;
        end else begin
            repeat (stall) push(st, 1'b0, 1'b0);
            push(st, 1'b1, 1'b0);
            ok = 1'b1;
        end
    endtask

    task automatic add_instr(input logic [6:0] o, input int sf, input int sm,
                             input bit z, input bit [2:0] f3, input bit rst_mid);
        bit ok;
        cur_op  = o;
        cur_f3  = f3;
        cur_z   = z;
        cur_ill = 1'b0;
        wait_seg(FETCH, sf, ok);
        if (!ok) return;
        push(DECODE, 1'($urandom), 1'b0);
        case (o)
            OP_LOAD: begin
                push(MEMADR, 1'($urandom), 1'b0);
                if (rst_mid) begin
                    push(MEMREAD, 1'b0, 1'b0);
                    push(MEMREAD, 1'b0, 1'b1);
                    return;
                end
                wait_seg(MEMREAD, sm, ok);
                if (ok) push(MEMWB, 1'($urandom), 1'b0);
            end
            OP_STORE: begin
                push(MEMADR, 1'($urandom), 1'b0);
                wait_seg(MEMWRITE, sm, ok);
            end
            OP_RTYPE: begin push(EXECR, 1'($urandom), 1'b0); push(ALUWB, 1'($urandom), 1'b0); end
            OP_ITYPE: begin push(EXECI, 1'($urandom), 1'b0); push(ALUWB, 1'($urandom), 1'b0); end
            OP_JAL:   begin push(JAL, 1'($urandom), 1'b0);   push(ALUWB, 1'($urandom), 1'b0); end
            OP_BRANCH: push(BRANCH, 1'($urandom), 1'b0);
            default:  trap_then_reset(1'b1);
        endcase
    endtask

    // {mem_req, MemWrite, IRWrite, PCWrite, RegWrite} expected for a cycle.
    function automatic logic [4:0] exp_en(input elem_t e);
        logic [4:0] v;
        case (e.st)
            FETCH:    v = {1'b1, 1'b0, e.mr, e.mr, 1'b0};
            MEMREAD:  v = 5'b10000;
            MEMWB:    v = 5'b00001;
            MEMWRITE: v = 5'b11000;
            ALUWB:    v = 5'b00001;
            JAL:      v = 5'b00010;
            BRANCH:   v = {3'b000, e.z ^ e.f3[0], 1'b0};
            default:  v = 5'b00000;
        endcase
        if (e.rst) v = 5'b00000;
        return v;
    endfunction

    // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp} expected for a state.
    function automatic logic [8:0] exp_sel(input int st);
        case (st)
            FETCH:    return {1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
            DECODE:   return {1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
            MEMADR:   return {1'b0, 2'b00, 2'b10, 2'b01, 2'b00};
            MEMREAD:  return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
            MEMWB:    return {1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
            MEMWRITE: return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
            EXECR:    return {1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
            EXECI:    return {1'b0, 2'b00, 2'b10, 2'b01, 2'b10};
            JAL:      return {1'b0, 2'b00, 2'b01, 2'b10, 2'b00};
            BRANCH:   return {1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
            default:  return 9'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        case (o)
            OP_STORE:  return 2'b01;
            OP_BRANCH: return 2'b10;
            OP_JAL:    return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 7))
            0: return OP_LOAD;
            1: return OP_STORE;
            2: return OP_RTYPE;
            3: return OP_ITYPE;
            4: return OP_BRANCH;
            5: return OP_JAL;
            6: return OP_LOAD;
            default: return ($urandom_range(0, 1) == 0) ? OP_BAD : OP_LUI;
        endcase
    endfunction

    function automatic int rand_stall();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return r % 4;
        if (r == 14) return WAIT_LIMIT - 1;
        if (r == 15) return WAIT_LIMIT;
        return $urandom_range(4, 8);
    endfunction

    initial begin
        elem_t e;
        logic [4:0] en;
`ifdef MC_PERF_CNT_EN
        int m_cyc, m_ins;
`endif

        // Directed cases first.
        add_instr(OP_RTYPE,  0, 0, 1'b0, 3'b000, 1'b0);
        add_instr(OP_LOAD,   0, 3, 1'b0, 3'b000, 1'b0);
        add_instr(OP_BRANCH, 0, 0, 1'b1, 3'b000, 1'b0);
        add_instr(OP_BRANCH, 0, 0, 1'b0, 3'b000, 1'b0);
        add_instr(OP_BRANCH, 0, 0, 1'b0, 3'b001, 1'b0);
        add_instr(OP_BRANCH, 0, 0, 1'b1, 3'b001, 1'b0);
        add_instr(OP_ITYPE,  WAIT_LIMIT, 0, 1'b0, 3'b000, 1'b0);
        add_instr(OP_ITYPE,  WAIT_LIMIT - 1, 0, 1'b0, 3'b000, 1'b0);
        add_instr(OP_BAD,    0, 0, 1'b0, 3'b000, 1'b0);
        add_instr(OP_STORE,  1, WAIT_LIMIT, 1'b0, 3'b000, 1'b0);
        add_instr(OP_LOAD,   0, 0, 1'b0, 3'b000, 1'b1);
        add_instr(OP_JAL,    2, 0, 1'b0, 3'b000, 1'b0);
        // Randomised program.
        for (int k = 0; k < 60; k++)
            add_instr(rand_op(), rand_stall(), rand_stall(), 1'($urandom), 3'($urandom),
                      ($urandom_range(0, 9) == 0));

        // Power-on reset: enables must be held low regardless of state.
        reset = 1'b1; op = OP_RTYPE; funct3 = 3'b000; Zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check("rst_en", {27'd0, mem_req, MemWrite, IRWrite, PCWrite, RegWrite}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
`ifdef MC_PERF_CNT_EN
        m_cyc = 0;
        m_ins = 0;
`endif

        for (int i = 0; i < trace.size(); i++) begin
            e = trace[i];
            cyc = i;
            reset = e.rst; op = e.op; funct3 = e.f3; Zero = e.z; mem_ready = e.mr;
            @(negedge clk);
            en = exp_en(e);
            check("state", {28'd0, state_o}, 32'(e.st));
            check("enables", {27'd0, mem_req, MemWrite, IRWrite, PCWrite, RegWrite}, {27'd0, en});
            check("selects", {23'd0, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}, {23'd0, exp_sel(e.st)});
            check("immsrc", {30'd0, ImmSrc}, {30'd0, exp_imm(e.op)});
            check("flags", {30'd0, trap, illegal_instr}, {30'd0, e.trp, e.ill});
`ifdef MC_PERF_CNT_EN
            check("cycle_cnt", cycle_cnt, 32'(m_cyc));
            check("instret_cnt", instret_cnt, 32'(m_ins));
            if (e.rst) begin
                m_cyc = 0;
                m_ins = 0;
            end else begin
                if (e.st != TRAP) m_cyc++;
                if ((i + 1 < trace.size()) && (trace[i + 1].st == FETCH) && (e.st != FETCH)) m_ins++;
            end
`endif
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
